dual_digit_scan: RTL and testbench

//  Downstream consumer of the tens/units separator. Drives a 2-digit multiplexed

---
 rtl/dual_digit_scan_pkg.sv | 56 +++++
 rtl/dual_digit_scan_seg7_encode.sv | 35 +++
 rtl/dual_digit_scan.sv | 147 ++++++++++++++
 tb/tb_dual_digit_scan.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_digit_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_digit_scan_pkg
// Description : Segment patterns, anode codes, phase encoding and tens decode
//               helpers shared by the dual-digit display scanner.
// Revision    : 1.0  initial release
// ============================================================================
package dual_digit_scan_pkg;

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        SHOW_U  = 2'd1,
        BLANK_T = 2'd2,
        SHOW_T  = 2'd3
    } phase_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Active-low {tens,units}
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    // Tens weight arrives as 0,10,..,90; a compare ladder avoids a divider.
    function automatic logic tens_valid(input logic [7:0] d);
        logic v;
        v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d == 8'(i * 10)) v = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [3:0] tens_digit(input logic [7:0] d);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (d == 8'(i * 10)) r = 4'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_digit_scan_seg7_encode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_encode
// Description : 4-bit digit plus invalid flag to active-low 7-segment pattern.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_encode
    import dual_digit_scan_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_invalid,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (!i_invalid) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dual_digit_scan.sv
`default_nettype none
// ============================================================================
// Module      : dual_digit_scan
// Description : Two-digit multiplexed common-anode 7-segment driver with
//               synchronised load strobe and anti-ghost blanking gaps.
// Revision    : 1.0  initial release
// ============================================================================
module dual_digit_scan
    import dual_digit_scan_pkg::*;
#(
    parameter int REFRESH_DIV     = 50000,
    parameter int BLANK_CYCLES    = 16,
    parameter int BLANK_LEAD_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic [7:0] unidades,
    input  logic [7:0] decenas,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic             r_s1, r_s2, r_s3;
    logic             w_fall;
    logic [7:0]       r_uni, r_dec;
    logic             r_err;
    logic             w_in_invalid;
    phase_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_phase_done;
    logic [6:0]       r_seg, w_seg_nxt;
    logic [1:0]       r_an, w_an_nxt;
    logic [6:0]       w_seg_units, w_seg_tens;
    logic             w_lead_zero;

    assign w_fall       = r_s3 & ~r_s2;
    assign w_in_invalid = (unidades > 8'd9) | ~tens_valid(decenas);
    assign w_lead_zero  = (BLANK_LEAD_ZERO != 0) && (r_dec == 8'd0);

    seg7_encode u_enc_units (
        .i_digit   (r_uni[3:0]),
        .i_invalid (r_uni > 8'd9),
        .o_seg     (w_seg_units)
    );

    seg7_encode u_enc_tens (
        .i_digit   (tens_digit(r_dec)),
        .i_invalid (~tens_valid(r_dec)),
        .o_seg     (w_seg_tens)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_done = 1'b0;
        w_seg_nxt    = r_seg;
        w_an_nxt     = r_an;

        case (r_state)
            BLANK_U: begin
                w_phase_done = (BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST);
                w_state_nxt  = SHOW_U;
            end
            SHOW_U: begin
                w_phase_done = (r_cnt == SHOW_LAST);
                w_state_nxt  = (BLANK_CYCLES == 0) ? SHOW_T : BLANK_T;
            end
            BLANK_T: begin
                w_phase_done = (BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST);
                w_state_nxt  = SHOW_T;
            end
            SHOW_T: begin
                w_phase_done = (r_cnt == SHOW_LAST);
                w_state_nxt  = (BLANK_CYCLES == 0) ? SHOW_U : BLANK_U;
            end
            default: begin
                w_phase_done = 1'b1;
                w_state_nxt  = BLANK_U;
            end
        endcase

        if (!w_phase_done) begin
            w_state_nxt = r_state;
        end else begin
            // Digit is frozen at phase entry, so a mid-phase capture never flickers.
            case (w_state_nxt)
                SHOW_U: begin
                    w_seg_nxt = w_seg_units;
                    w_an_nxt  = AN_UNITS;
                end
                SHOW_T: begin
                    if (w_lead_zero) begin
                        w_seg_nxt = SEG_OFF;
                        w_an_nxt  = AN_OFF;
                    end else begin
                        w_seg_nxt = w_seg_tens;
                        w_an_nxt  = AN_TENS;
                    end
                end
                default: begin
                    w_seg_nxt = SEG_OFF;
                    w_an_nxt  = AN_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_uni   <= 8'd0;
            r_dec   <= 8'd0;
            r_err   <= 1'b0;
            r_state <= BLANK_U;
            r_cnt   <= '0;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
        end else begin
            r_s1 <= update;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_fall) begin
                r_uni <= unidades;
                r_dec <= decenas;
                r_err <= w_in_invalid;
            end
            r_state <= w_state_nxt;
            r_cnt   <= w_phase_done ? '0 : r_cnt + CNT_W'(1);
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dual_digit_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_digit_scan
// Description : Self-checking bench: schedule-based reference model plus
//               directed literal checks and randomized load traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dual_digit_scan;

    localparam int R = 4;
    localparam int B = 1;
    localparam int P = 2 * (R + B);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       update = 1'b0;
    logic [7:0] unidades = 8'd0;
    logic [7:0] decenas = 8'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int total = 0;
    int bad   = 0;

    dual_digit_scan #(
        .REFRESH_DIV     (R),
        .BLANK_CYCLES    (B),
        .BLANK_LEAD_ZERO (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .update   (update),
        .unidades (unidades),
        .decenas  (decenas),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [6:0] TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;

    function automatic logic [6:0] units_pat(input int u);
        return (u <= 9) ? TAB[u] : DASH;
    endfunction

    function automatic logic tens_ok(input int t);
        return (t % 10 == 0) && (t <= 90);
    endfunction

    function automatic logic [6:0] tens_pat(input int t);
        return tens_ok(t) ? TAB[t / 10] : DASH;
    endfunction

    // 0=BLANK_U 1=SHOW_U 2=BLANK_T 3=SHOW_T, from position in the scan period
    function automatic int phase_of(input int pos);
        if (pos < B)         return 0;
        if (pos < B + R)     return 1;
        if (pos < 2 * B + R) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position counts edges since reset release.
    bit         model_valid = 0;
    int         m_k = 0;
    bit         h1 = 0, h2 = 0, h3 = 0;
    int         sh_u = 0, sh_t = 0;
    logic [6:0] m_seg = 7'h7F;
    logic [1:0] m_an = 2'b11;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_valid = 1;
            m_k = 0; h1 = 0; h2 = 0; h3 = 0;
            sh_u = 0; sh_t = 0;
            m_seg = 7'h7F; m_an = 2'b11; m_err = 1'b0;
        end else if (model_valid) begin
            bit fall;
            int prev, cur;
            fall = h3 && !h2;
            prev = phase_of(m_k % P);
            m_k++;
            cur  = phase_of(m_k % P);
            if (cur != prev) begin
                if (cur == 1) begin
                    m_seg = units_pat(sh_u); m_an = 2'b10;
                end else if (cur == 3 && sh_t != 0) begin
                    m_seg = tens_pat(sh_t); m_an = 2'b01;
                end else begin
                    m_seg = 7'h7F; m_an = 2'b11;
                end
            end
            if (fall) begin
                sh_u  = int'(unidades);
                sh_t  = int'(decenas);
                m_err = (sh_u > 9) || !tens_ok(sh_t);
            end
            h3 = h2; h2 = h1; h1 = update;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_seg", {1'b0, seg}, {1'b0, m_seg});
            chk("model_an",  {6'b0, an},  {6'b0, m_an});
            chk("model_err", {7'b0, err}, {7'b0, m_err});
        end
    end

    task automatic wait_an(input logic [1:0] t, input int maxc);
        int n = 0;
        while (an !== t && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_an", {6'b0, an}, {6'b0, t});
    endtask

    task automatic load(input logic [7:0] u, input logic [7:0] d);
        unidades = u;
        decenas  = d;
        update   = 1'b1;
        repeat (2) @(negedge clk);
        update = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic next_show_u();
        wait_an(2'b11, 12);
        wait_an(2'b10, 12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c10, c01;

        repeat (3) @(negedge clk);
        chk("rst_an",  {6'b0, an},  8'h03);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_err", {7'b0, err}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_an",  {6'b0, an},  8'h02);
        chk("rel_seg", {1'b0, seg}, {1'b0, 7'b1000000});
        @(negedge clk);

        load(8'd5, 8'd40);
        next_show_u();
        chk("s2_units", {1'b0, seg}, {1'b0, 7'b0010010});
        wait_an(2'b01, 12);
        chk("s2_tens",  {1'b0, seg}, {1'b0, 7'b0011001});
        chk("s2_err",   {7'b0, err}, 8'h00);

        load(8'd7, 8'd0);
        next_show_u();
        chk("s3_units", {1'b0, seg}, {1'b0, 7'b1111000});
        c10 = 0; c01 = 0;
        for (int i = 0; i < P; i++) begin
            if (an == 2'b10) c10++;
            if (an == 2'b01) c01++;
            @(negedge clk);
        end
        chk("s3_units_len", 8'(c10), 8'd4);
        chk("s3_tens_lit",  8'(c01), 8'd0);

        load(8'd12, 8'd45);
        chk("s4_err", {7'b0, err}, 8'h01);
        next_show_u();
        chk("s4_u_dash", {1'b0, seg}, {1'b0, DASH});
        wait_an(2'b01, 12);
        chk("s4_t_dash", {1'b0, seg}, {1'b0, DASH});
        load(8'd3, 8'd30);
        chk("s4_err_clr", {7'b0, err}, 8'h00);
        next_show_u();
        chk("s4_u3", {1'b0, seg}, {1'b0, 7'b0110000});
        wait_an(2'b01, 12);
        chk("s4_t3", {1'b0, seg}, {1'b0, 7'b0110000});

        load(8'd5, 8'd40);
        update = 1'b1;
        wait_an(2'b01, 12);
        wait_an(2'b10, 12);
        unidades = 8'd8;
        decenas  = 8'd80;
        update   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_hold_seg", {1'b0, seg}, {1'b0, 7'b0010010});
            chk("s5_hold_an",  {6'b0, an},  8'h02);
        end
        wait_an(2'b01, 12);
        chk("s5_t8", {1'b0, seg}, {1'b0, 7'b0000000});
        wait_an(2'b10, 12);
        chk("s5_u8", {1'b0, seg}, {1'b0, 7'b0000000});

        load(8'd12, 8'd45);
        chk("s6_err_pre", {7'b0, err}, 8'h01);
        wait_an(2'b01, 12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("s6_an",  {6'b0, an},  8'h03);
        chk("s6_seg", {1'b0, seg}, 8'h7F);
        chk("s6_err", {7'b0, err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("s6_rel_an",  {6'b0, an},  8'h02);
        chk("s6_rel_seg", {1'b0, seg}, {1'b0, 7'b1000000});
        @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n = ($urandom % 250) != 0;
            if ($urandom % 6 == 0) update = ~update;
            if ($urandom % 3 == 0)
                unidades = ($urandom % 4 == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom % 10);
            if ($urandom % 3 == 0)
                decenas = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'(($urandom % 10) * 10);
        end
        rst_n = 1'b1;
        repeat (3 * P) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
